// File: rtl/tetris_pkg.sv
// Shared game-flow types and constants for the piece sequencer.
// Holds the FSM state enum, PS/2 scan codes, move step and grid size.
package tetris_pkg;

    typedef enum logic [2:0] {
        ST_FALL,
        ST_LOCK,
        ST_SCAN,
        ST_SETTLE,
        ST_DONE,
        ST_SPAWN,
        ST_GAME_OVER
    } state_t;

    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6b;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    localparam int SIZE      = 16;
    localparam int GRID_ROWS = 30;
    localparam int NUM_TYPES = 11;

    // Line count reported to scoring saturates at 7 (3-bit field).
    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

endpackage

// File: rtl/piece_sequencer_gravity_timer.sv
// Gravity tick generator: counts enabled clocks, pulses tick every TICK_PERIOD.
// Ports: iVGA_CLK, rst (sync high), en (count), clr (zero counter), tick (pulse).
module gravity_timer #(
    parameter int TICK_PERIOD = 10000000
) (
    input  logic iVGA_CLK,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_PERIOD - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge iVGA_CLK) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/piece_sequencer.sv
// Falling-piece game-flow controller: one move per cycle, then lock/scan/score/spawn.
// Ports: iVGA_CLK, rst, key/rotate/LFSR/collision inputs; ref/type, pulses, score, game_over out.
module piece_sequencer
    import tetris_pkg::*;
#(
    parameter int SIZE_P      = SIZE,
    parameter int SPAWN_X     = 320,
    parameter int SPAWN_Y     = 0,
    parameter int TICK_PERIOD = 10000000,
    parameter int ROWS        = GRID_ROWS,
    parameter int N_TYPES     = NUM_TYPES
) (
    input  logic       iVGA_CLK,
    input  logic       rst,
    input  logic [7:0] key_in,
    input  logic       key_en,
    input  logic       rot_req,
    input  logic [3:0] rot_type,
    input  logic [12:0] rand_in,
    input  logic       stop_down,
    input  logic       stop_left,
    input  logic       stop_right,
    input  logic       stop_rotate,
    input  logic       row_full,
    output logic [9:0] ref_x,
    output logic [9:0] ref_y,
    output logic [3:0] block_type,
    output logic       rotate,
    output logic       lock,
    output logic [4:0] scan_row,
    output logic       shift_row,
    output logic [2:0] add_points,
    output logic       points_valid,
    output logic       game_over
);

    localparam logic [9:0] STEP = 10'(SIZE_P);
    localparam logic [9:0] SX   = 10'(SPAWN_X);
    localparam logic [9:0] SY   = 10'(SPAWN_Y);

    state_t     state, state_n;
    logic [9:0] x_n, y_n;
    logic [3:0] type_n;
    logic       rot_n;
    logic [4:0] scan_n;
    logic [2:0] lines, lines_n;
    logic       kv, kv_n;
    logic [7:0] kbuf, kbuf_n;
    logic       tick;

    gravity_timer #(
        .TICK_PERIOD(TICK_PERIOD)
    ) u_timer (
        .iVGA_CLK(iVGA_CLK),
        .rst     (rst),
        .en      (state == ST_FALL),
        .clr     (state == ST_SPAWN),
        .tick    (tick)
    );

    always_comb begin
        state_n = state;
        x_n     = ref_x;
        y_n     = ref_y;
        type_n  = block_type;
        rot_n   = 1'b0;
        scan_n  = scan_row;
        lines_n = lines;
        kv_n    = kv;
        kbuf_n  = kbuf;

        unique case (state)
            ST_FALL: begin
                if (tick) begin
                    if (stop_down) state_n = ST_LOCK;
                    else           y_n = ref_y + STEP;
                end else if (kv) begin
                    // A buffered key is consumed even when the move is blocked.
                    kv_n = 1'b0;
                    case (kbuf)
                        KEY_DOWN:  if (!stop_down)  y_n = ref_y + STEP;
                        KEY_LEFT:  if (!stop_left)  x_n = ref_x - STEP;
                        KEY_RIGHT: if (!stop_right) x_n = ref_x + STEP;
                        KEY_UP:    rot_n = 1'b1;
                        default:   ;
                    endcase
                end else if (rot_req && !stop_rotate) begin
                    type_n = rot_type;
                end
            end
            ST_LOCK: begin
                if (ref_y == SY) begin
                    state_n = ST_GAME_OVER;
                end else begin
                    scan_n  = 5'(ROWS - 1);
                    lines_n = '0;
                    state_n = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (row_full) begin
                    lines_n = sat_inc(lines);
                    state_n = ST_SETTLE;
                end else if (scan_row == '0) begin
                    state_n = ST_DONE;
                end else begin
                    scan_n = scan_row - 5'd1;
                end
            end
            // Grid is still shifting; row_full is stale for this cycle.
            ST_SETTLE: state_n = ST_SCAN;
            ST_DONE:   state_n = ST_SPAWN;
            ST_SPAWN: begin
                x_n     = SX;
                y_n     = SY;
                type_n  = 4'(rand_in % 13'(N_TYPES));
                kv_n    = 1'b0;
                state_n = ST_FALL;
            end
            ST_GAME_OVER: ;
            default: state_n = ST_FALL;
        endcase

        // Latest code wins, including over a same-cycle serve or spawn clear.
        if (key_en && state != ST_GAME_OVER) begin
            kv_n   = 1'b1;
            kbuf_n = key_in;
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (rst) begin
            state      <= ST_FALL;
            ref_x      <= SX;
            ref_y      <= SY;
            block_type <= '0;
            rotate     <= 1'b0;
            scan_row   <= '0;
            lines      <= '0;
            kv         <= 1'b0;
            kbuf       <= '0;
        end else begin
            state      <= state_n;
            ref_x      <= x_n;
            ref_y      <= y_n;
            block_type <= type_n;
            rotate     <= rot_n;
            scan_row   <= scan_n;
            lines      <= lines_n;
            kv         <= kv_n;
            kbuf       <= kbuf_n;
        end
    end

    assign lock         = (state == ST_LOCK);
    assign shift_row    = (state == ST_SCAN) && row_full;
    assign points_valid = (state == ST_DONE) && (lines != '0);
    assign add_points   = points_valid ? lines : 3'd0;
    assign game_over    = (state == ST_GAME_OVER);

endmodule

// File: tb/tb_piece_sequencer.sv
// Scoreboard bench for piece_sequencer: reference model pushes expectations,
// monitor pops and compares one step after each clock edge.
module tb_piece_sequencer;

    localparam int TP = 8;

    logic        iVGA_CLK = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  key_in = '0;
    logic        key_en = 1'b0;
    logic        rot_req = 1'b0;
    logic [3:0]  rot_type = '0;
    logic [12:0] rand_in = '0;
    logic        stop_down = 1'b0;
    logic        stop_left = 1'b0;
    logic        stop_right = 1'b0;
    logic        stop_rotate = 1'b0;
    logic        row_full = 1'b0;
    logic [9:0]  ref_x, ref_y;
    logic [3:0]  block_type;
    logic        rotate, lock, shift_row, points_valid, game_over;
    logic [4:0]  scan_row;
    logic [2:0]  add_points;

    piece_sequencer #(.TICK_PERIOD(TP)) dut (
        .iVGA_CLK(iVGA_CLK), .rst(rst),
        .key_in(key_in), .key_en(key_en),
        .rot_req(rot_req), .rot_type(rot_type),
        .rand_in(rand_in),
        .stop_down(stop_down), .stop_left(stop_left),
        .stop_right(stop_right), .stop_rotate(stop_rotate),
        .row_full(row_full),
        .ref_x(ref_x), .ref_y(ref_y), .block_type(block_type),
        .rotate(rotate), .lock(lock), .scan_row(scan_row),
        .shift_row(shift_row), .add_points(add_points),
        .points_valid(points_valid), .game_over(game_over)
    );

    always #5 iVGA_CLK = ~iVGA_CLK;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] t;
        logic       rot;
        logic       lk;
        logic [4:0] scan;
        logic       sh;
        logic [2:0] ap;
        logic       pv;
        logic       go;
    } obs_t;

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: game phases as plain integers.
    localparam int P_FALL = 0, P_LOCK = 1, P_SCAN = 2, P_WAIT = 3;
    localparam int P_SCORE = 4, P_NEW = 5, P_OVER = 6;

    int         m_st = P_FALL;
    int         m_cnt = 0;
    int         m_lines = 0;
    int         m_scan = 0;
    logic [9:0] m_x = 10'd320, m_y = 10'd0;
    int         m_type = 0;
    bit         m_rot = 0;
    bit         m_kv = 0;
    logic [7:0] m_kbuf = '0;

    task automatic model_step();
        int st0;
        st0 = m_st;
        m_rot = 0;
        if (rst) begin
            m_st = P_FALL; m_cnt = 0; m_lines = 0; m_scan = 0;
            m_x = 10'd320; m_y = 10'd0; m_type = 0; m_kv = 0; m_kbuf = '0;
            return;
        end
        case (st0)
            P_FALL: begin
                if (m_cnt == TP - 1) begin
                    m_cnt = 0;
                    if (stop_down) m_st = P_LOCK;
                    else m_y = m_y + 10'd16;
                end else begin
                    m_cnt = m_cnt + 1;
                    if (m_kv) begin
                        m_kv = 0;
                        if (m_kbuf == 8'h72 && !stop_down) m_y = m_y + 10'd16;
                        if (m_kbuf == 8'h6b && !stop_left) m_x = m_x - 10'd16;
                        if (m_kbuf == 8'h74 && !stop_right) m_x = m_x + 10'd16;
                        if (m_kbuf == 8'h75) m_rot = 1;
                    end else if (rot_req && !stop_rotate) begin
                        m_type = int'(rot_type);
                    end
                end
            end
            P_LOCK: begin
                if (m_y == 10'd0) m_st = P_OVER;
                else begin m_scan = 29; m_lines = 0; m_st = P_SCAN; end
            end
            P_SCAN: begin
                if (row_full) begin m_lines++; m_st = P_WAIT; end
                else if (m_scan == 0) m_st = P_SCORE;
                else m_scan--;
            end
            P_WAIT:  m_st = P_SCAN;
            P_SCORE: m_st = P_NEW;
            P_NEW: begin
                m_x = 10'd320; m_y = 10'd0;
                m_type = int'(rand_in) % 11;
                m_cnt = 0; m_kv = 0; m_st = P_FALL;
            end
            default: ;
        endcase
        if (key_en && st0 != P_OVER) begin
            m_kv = 1; m_kbuf = key_in;
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.x    = m_x;
        o.y    = m_y;
        o.t    = 4'(m_type);
        o.rot  = m_rot;
        o.lk   = (m_st == P_LOCK);
        o.scan = 5'(m_scan);
        o.sh   = (m_st == P_SCAN) && row_full;
        o.pv   = (m_st == P_SCORE) && (m_lines != 0);
        o.ap   = o.pv ? 3'((m_lines > 7) ? 7 : m_lines) : 3'd0;
        o.go   = (m_st == P_OVER);
        return o;
    endfunction

    always @(posedge iVGA_CLK) begin
        model_step();
        exp_q.push_back(model_obs());
    end

    always @(posedge iVGA_CLK) begin
        obs_t e, g;
        #1;
        g = '{ref_x, ref_y, block_type, rotate, lock, scan_row,
              shift_row, add_points, points_valid, game_over};
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty t=%0t", $time);
        end else begin
            e = exp_q.pop_front();
            if (g !== e) begin
                miscompares++;
                $display("FAIL outputs t=%0t got x=%0d y=%0d t=%0d rot=%b lk=%b scan=%0d sh=%b ap=%0d pv=%b go=%b required x=%0d y=%0d t=%0d rot=%b lk=%b scan=%0d sh=%b ap=%0d pv=%b go=%b",
                    $time, g.x, g.y, g.t, g.rot, g.lk, g.scan, g.sh, g.ap, g.pv, g.go,
                    e.x, e.y, e.t, e.rot, e.lk, e.scan, e.sh, e.ap, e.pv, e.go);
            end
        end
    end

    task automatic cyc();
        @(posedge iVGA_CLK);
        #2;
        key_en = 1'b0;
    endtask

    task automatic press(input logic [7:0] k);
        key_in = k;
        key_en = 1'b1;
        cyc();
    endtask

    task automatic timeout(input string what);
        vectors++;
        miscompares++;
        $display("FAIL wait_%s expired", what);
    endtask

    task automatic wait_tick_next();
        int n = 0;
        while (m_cnt != TP - 1 && n < 40) begin cyc(); n++; end
        if (m_cnt != TP - 1) timeout("tick");
    endtask

    task automatic wait_state(input int st, input int lim, input string what);
        int n = 0;
        while (m_st != st && n < lim) begin cyc(); n++; end
        if (m_st != st) timeout(what);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge iVGA_CLK);
        #2 rst = 1'b0;
        repeat (30) cyc();

        press(8'h6b);
        repeat (3) cyc();
        stop_left = 1'b1;
        press(8'h6b);
        repeat (3) cyc();
        stop_left = 1'b0;

        wait_tick_next();
        press(8'h74);
        repeat (3) cyc();

        press(8'h75);
        repeat (2) cyc();
        rot_req = 1'b1; rot_type = 4'd4;
        repeat (2) cyc();
        stop_rotate = 1'b1; rot_type = 4'd7;
        repeat (2) cyc();
        rot_req = 1'b0; stop_rotate = 1'b0;

        n = 0;
        while (!(m_st == P_FALL && m_y == 10'd448) && n < 1000) begin cyc(); n++; end
        if (m_y != 10'd448) timeout("y448");
        stop_down = 1'b1;
        rand_in = 13'd1234;
        wait_state(P_LOCK, 40, "lock");
        stop_down = 1'b0;
        n = 0;
        while (m_st != P_SCORE && n < 200) begin
            row_full = (m_lines < 2);
            cyc();
            n++;
        end
        if (m_st != P_SCORE) timeout("score");
        row_full = 1'b0;
        wait_state(P_FALL, 10, "spawn");

        stop_down = 1'b1;
        wait_state(P_OVER, 40, "game_over");
        stop_down = 1'b0;
        press(8'h6b);
        rot_req = 1'b1; rot_type = 4'd9;
        repeat (5) cyc();
        rot_req = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (3) cyc();

        for (int i = 0; i < 4000; i++) begin
            int k;
            k = $urandom_range(0, 5);
            key_in = (k == 0) ? 8'h72 : (k == 1) ? 8'h6b : (k == 2) ? 8'h74 :
                     (k == 3) ? 8'h75 : 8'($urandom);
            key_en      = ($urandom_range(0, 3) == 0);
            rot_req     = ($urandom_range(0, 5) == 0);
            rot_type    = 4'($urandom);
            rand_in     = 13'($urandom);
            stop_down   = ($urandom_range(0, 9) == 0);
            stop_left   = ($urandom_range(0, 2) == 0);
            stop_right  = ($urandom_range(0, 2) == 0);
            stop_rotate = ($urandom_range(0, 2) == 0);
            row_full    = ($urandom_range(0, 2) == 0);
            rst         = (m_st == P_OVER && $urandom_range(0, 7) == 0) ||
                          ($urandom_range(0, 499) == 0);
            @(posedge iVGA_CLK);
            #2;
        end
        rst = 1'b0; key_en = 1'b0;
        repeat (3) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
